sram_access_arbiter: RTL and testbench
======================================

Name: sram_access_arbiter

Overview:
- Shares the single external 8-bit asynchronous SRAM (19-bit address) between pReqNum internal requesters: display line fetch, SPI-slave PSRAM/data write path, and the system CSR path.
- Round-robin arbitration, one byte access per grant.
- Generates CE/OE/WE strobes and the DQ output-enable; the tristate buffer itself lives at the top level.

Parameters:
pReqNum, 3, number of requesters (2..4); index 0 = display fetch
pAdrsW, 19, SRAM address width
pDataW, 8, SRAM data width
pAccessCyc, 3, cycles OE/WE held low (1..15); ≥ SRAM tAA/tWP at system clock
pUrgentEn, 1, 1 = requester 0 wins whenever iUrgent is high, overriding round-robin

Ports:
iSysClk  in  1  system clock
iSysRst  in  1  reset; synchronous, active-low
iReqVd  in  pReqNum  per-requester request valid; held until oReqAck
iReqWe  in  pReqNum  1 = write, 0 = read
iReqAdrs  in  pReqNum*pAdrsW  packed addresses, requester k at [k*pAdrsW +: pAdrsW]
iReqWd  in  pReqNum*pDataW  packed write data
iUrgent  in  1  display FIFO near-empty
oReqAck  out  pReqNum  one-hot 1-cycle pulse: request consumed (at grant)
oRd  out  pDataW  read data
oRdVd  out  pReqNum  one-hot 1-cycle pulse: oRd valid for that requester
oBusy  out  1  state != IDLE
oMemAdrs  out  pAdrsW  SRAM address
oMemWd  out  pDataW  SRAM write data
iMemRd  in  pDataW  SRAM DQ input
oMemDqOe  out  1  1 = FPGA drives DQ
oMemCE  out  1  chip enable, active-low
oMemOE  out  1  output enable, active-low
oMemWE  out  1  write enable, active-low

Behaviour:
- Reset (iSysRst=0 at a clock edge), all outputs registered:
  - oMemCE = oMemOE = oMemWE = 1; oMemDqOe = 0.
  - oMemAdrs, oMemWd, oRd = 0; oReqAck, oRdVd = 0; oBusy = 0.
  - Round-robin pointer = 0.
- Reset mid-access: strobes return high on the next edge and the pending transaction is dropped with no ack and no RdVd. Requesters re-issue.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
  - IDLE: if any iReqVd, select winner, latch adrs/we/wd/id, pulse oReqAck[winner], go to SETUP. Otherwise stay.
  - SETUP (1 cycle): oMemAdrs valid, oMemCE = 0. For a write, oMemDqOe = 1 with oMemWd valid. Go to ACCESS with counter = pAccessCyc-1.
  - ACCESS (pAccessCyc cycles): read drives oMemOE = 0; write drives oMemWE = 0. Counter decrements. At counter = 0: a read captures iMemRd into oRd; go to HOLD.
  - HOLD (1 cycle): OE/WE = 1, CE stays 0, address/data/DqOe held. For a read, oRdVd[id] pulses this cycle. Go to IDLE.
- Read-write contention: oMemDqOe is never 1 while oMemOE = 0.
- Address and data are stable for the whole SETUP..HOLD window. WE rises at least 1 cycle before address or data change.
- Throughput: one access per pAccessCyc+3 cycles. No back-to-back shortcut.
- Latency, read: ack at cycle T (the IDLE edge); oRdVd at T+pAccessCyc+2. With the default pAccessCyc = 3, oRdVd is at T+5.
- Arbitration:
  - If pUrgentEn and iUrgent and iReqVd[0], requester 0 wins.
  - Otherwise search from the pointer upward with wrap; the first valid requester wins. The pointer becomes winner+1 mod pReqNum.
  - An urgent win also moves the pointer to 1.
- Simultaneous events:
  - Requests arriving while busy wait; they are evaluated only in IDLE.
  - iReqVd dropped before ack is permitted and is ignored.
  - iUrgent changes are sampled only in IDLE.
- oReqAck and oRdVd are never asserted for more than one requester in the same cycle.

Test Plan:
- Single write, requester 1, adrs 0x0_0AAA, data 0x5A -> ack[1] at T. Then:
  - SETUP: CE=0, DqOe=1.
  - WE low for exactly 3 cycles; adrs/data stable throughout.
  - All strobes high at T+6.
- Read, requester 2, adrs 0x7_FFFF, SRAM model returns 0xC3 -> oRdVd = 3'b100 at T+5, oRd = 0xC3. DqOe = 0 throughout and OE low for 3 cycles.
- All three requesters held valid, iUrgent=0 -> grants in order 0,1,2,0,1,2, exactly 6 cycles apart.
- iUrgent=1 with all valid, pointer at 2 -> requester 0 granted and the pointer becomes 1. Next grant with iUrgent=0 goes to 1.
- Write immediately followed by read on the same address -> read returns the written byte, and DqOe=1 never overlaps OE=0.
- iSysRst=0 asserted in ACCESS of a read -> next cycle CE/OE/WE=1, DqOe=0, no oRdVd. After release, the held request is re-granted and completes normally.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - round-robin arbiter and strobe sequencer for one external async SRAM
//
// Purpose: shares a single 8-bit asynchronous SRAM between pReqNum requesters,
// one byte per grant. Requester 0 (display fetch) may pre-empt round-robin via iUrgent.
// Strobe outputs are registered. Each one reflects the state the FSM held in the
// previous cycle, so every SRAM phase appears one cycle after the FSM enters it.
//
// Ports:
//   iSysClk, iSysRst         clock, synchronous active-low reset
//   iReqVd/iReqWe            per-requester request valid / write select
//   iReqAdrs/iReqWd          packed per-requester address / write data
//   iUrgent                  display FIFO near-empty, favours requester 0
//   oReqAck                  one-hot pulse when a request is consumed
//   oRd/oRdVd                read data and one-hot pulse marking it valid
//   oBusy                    FSM not idle
//   oMemAdrs/oMemWd          SRAM address / write data
//   iMemRd                   SRAM DQ input
//   oMemDqOe                 1 = drive DQ (tristate lives at top level)
//   oMemCE/oMemOE/oMemWE     active-low SRAM strobes
module sram_access_arbiter #(
  parameter int pReqNum    = 3,
  parameter int pAdrsW     = 19,
  parameter int pDataW     = 8,
  parameter int pAccessCyc = 3,
  parameter int pUrgentEn  = 1
) (
  input  logic                        iSysClk,
  input  logic                        iSysRst,
  input  logic [pReqNum-1:0]          iReqVd,
  input  logic [pReqNum-1:0]          iReqWe,
  input  logic [pReqNum*pAdrsW-1:0]   iReqAdrs,
  input  logic [pReqNum*pDataW-1:0]   iReqWd,
  input  logic                        iUrgent,
  output logic [pReqNum-1:0]          oReqAck,
  output logic [pDataW-1:0]           oRd,
  output logic [pReqNum-1:0]          oRdVd,
  output logic                        oBusy,
  output logic [pAdrsW-1:0]           oMemAdrs,
  output logic [pDataW-1:0]           oMemWd,
  input  logic [pDataW-1:0]           iMemRd,
  output logic                        oMemDqOe,
  output logic                        oMemCE,
  output logic                        oMemOE,
  output logic                        oMemWE
);

  localparam int IDW = (pReqNum > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic                we_q, we_d;
  logic [pAdrsW-1:0]   adrs_q, adrs_d;
  logic [pDataW-1:0]   wd_q, wd_d;
  logic [pDataW-1:0]   rd_q, rd_d;
  logic [pReqNum-1:0]  ack_q, ack_d;
  logic [pReqNum-1:0]  rdvd_q, rdvd_d;
  logic                busy_q, busy_d;
  logic                ce_q, ce_d;
  logic                oe_q, oe_d;
  logic                wen_q, wen_d;
  logic                dqoe_q, dqoe_d;

  logic                win_found;
  logic [IDW-1:0]      win_id;
  logic [IDW:0]        scan_sum;
  logic [IDW-1:0]      scan_idx;
  logic [pAdrsW-1:0]   win_adrs;
  logic [pDataW-1:0]   win_wd;

  // Winner selection: urgent display fetch first, otherwise scan upward from the pointer with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    if ((pUrgentEn != 0) && iUrgent && iReqVd[0]) begin
      win_found = 1'b1;
      win_id    = '0;
    end else begin
      for (int k = 0; k < pReqNum; k++) begin
        scan_sum = {1'b0, ptr_q} + (IDW+1)'(k);
        if (scan_sum >= (IDW+1)'(pReqNum)) begin
          scan_sum = scan_sum - (IDW+1)'(pReqNum);
        end
        scan_idx = scan_sum[IDW-1:0];
        if (!win_found && iReqVd[scan_idx]) begin
          win_found = 1'b1;
          win_id    = scan_idx;
        end
      end
    end
    win_adrs = '0;
    win_wd   = '0;
    for (int k = 0; k < pReqNum; k++) begin
      if (win_id == IDW'(k)) begin
        win_adrs = iReqAdrs[k*pAdrsW +: pAdrsW];
        win_wd   = iReqWd[k*pDataW +: pDataW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    we_d    = we_q;
    adrs_d  = adrs_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    ack_d   = '0;
    rdvd_d  = '0;
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    wen_d   = 1'b1;
    dqoe_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d        = ST_SETUP;
          ack_d[win_id]  = 1'b1;
          id_d           = win_id;
          we_d           = iReqWe[win_id];
          adrs_d         = win_adrs;
          if (iReqWe[win_id]) begin
            wd_d = win_wd;
          end
          // An urgent grant is always requester 0, so winner+1 covers it too.
          ptr_d = (win_id == IDW'(pReqNum-1)) ? '0 : win_id + IDW'(1);
        end
      end
      ST_SETUP: begin
        ce_d    = 1'b0;
        dqoe_d  = we_q;
        cnt_d   = 4'(pAccessCyc-1);
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        ce_d   = 1'b0;
        dqoe_d = we_q;
        oe_d   = we_q;
        wen_d  = ~we_q;
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        // OE is still low on the pins during this cycle, so iMemRd is the addressed byte.
        ce_d   = 1'b0;
        dqoe_d = we_q;
        if (!we_q) begin
          rd_d           = iMemRd;
          rdvd_d[id_q]   = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge iSysClk) begin
    if (!iSysRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      we_q    <= 1'b0;
      adrs_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      ack_q   <= '0;
      rdvd_q  <= '0;
      busy_q  <= 1'b0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      wen_q   <= 1'b1;
      dqoe_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      we_q    <= we_d;
      adrs_q  <= adrs_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      rdvd_q  <= rdvd_d;
      busy_q  <= busy_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      wen_q   <= wen_d;
      dqoe_q  <= dqoe_d;
    end
  end

  assign oReqAck  = ack_q;
  assign oRd      = rd_q;
  assign oRdVd    = rdvd_q;
  assign oBusy    = busy_q;
  assign oMemAdrs = adrs_q;
  assign oMemWd   = wd_q;
  assign oMemDqOe = dqoe_q;
  assign oMemCE   = ce_q;
  assign oMemOE   = oe_q;
  assign oMemWE   = wen_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - self-checking bench for sram_access_arbiter
module tb_sram_access_arbiter;

  localparam int N  = 3;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int A  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      vd = '0;
  logic [N-1:0]      we = '0;
  logic [N*AW-1:0]   adrs = '0;
  logic [N*DW-1:0]   wd = '0;
  logic              urg = 1'b0;
  logic [N-1:0]      ack, rdvd;
  logic [DW-1:0]     rd, mem_wd, mem_rd;
  logic [AW-1:0]     mem_adrs;
  logic              busy, dqoe, ce_n, oe_n, we_n;

  sram_access_arbiter #(
    .pReqNum(N), .pAdrsW(AW), .pDataW(DW), .pAccessCyc(A), .pUrgentEn(1)
  ) dut (
    .iSysClk(clk), .iSysRst(rst_n), .iReqVd(vd), .iReqWe(we), .iReqAdrs(adrs),
    .iReqWd(wd), .iUrgent(urg), .oReqAck(ack), .oRd(rd), .oRdVd(rdvd), .oBusy(busy),
    .oMemAdrs(mem_adrs), .oMemWd(mem_wd), .iMemRd(mem_rd), .oMemDqOe(dqoe),
    .oMemCE(ce_n), .oMemOE(oe_n), .oMemWE(we_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // SRAM device model and independent reference memory.
  logic [DW-1:0] sram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) if (!ce_n && !we_n) sram[mem_adrs] <= mem_wd;
  assign mem_rd = (!oe_n) ? sram[mem_adrs] : 8'hEE;

  // Requester agents: present the head of each queue, pop it when acked.
  typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} req_t;
  req_t rq[N][$];

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (ack[k] && rq[k].size() > 0) void'(rq[k].pop_front());
      if (rq[k].size() > 0) begin
        vd[k] = 1'b1;
        we[k] = rq[k][0].w;
        adrs[k*AW +: AW] = rq[k][0].a;
        wd[k*DW +: DW] = rq[k][0].d;
      end else begin
        vd[k] = 1'b0;
      end
    end
  end

  // Transaction-level model: a grant at cycle T implies the whole strobe timeline.
  bit            m_valid = 1'b0;
  int            m_T = 0;
  int            m_id = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_adrs = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_rd = '0;
  logic [DW-1:0] m_rdexp = '0;
  int            m_ptr = 0;

  int g_cyc[$], g_id[$], r_cyc[$];
  logic [N-1:0] r_vec[$];
  logic [DW-1:0] r_dat[$];
  int we_run = 0, oe_run = 0, last_we_run = 0, last_oe_run = 0;

  function automatic bit inwin(int c, int lo, int hi);
    return m_valid && (c >= m_T + lo) && (c <= m_T + hi);
  endfunction

  function automatic int oh2i(logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int c;
      int w;
      logic [N-1:0] e_ack, e_rdvd;
      c = cyc;
      e_ack  = (m_valid && c == m_T) ? N'(1 << m_id) : '0;
      e_rdvd = (m_valid && !m_we && c == m_T + A + 2) ? N'(1 << m_id) : '0;
      chk("ack", 32'(ack), 32'(e_ack));
      chk("rdvd", 32'(rdvd), 32'(e_rdvd));
      chk("busy", 32'(busy), 32'(inwin(c, 0, A + 1)));
      chk("ce_n", 32'(ce_n), 32'(!inwin(c, 1, A + 2)));
      chk("dqoe", 32'(dqoe), 32'(m_we && inwin(c, 1, A + 2)));
      chk("oe_n", 32'(oe_n), 32'(!(!m_we && inwin(c, 2, A + 1))));
      chk("we_n", 32'(we_n), 32'(!(m_we && inwin(c, 2, A + 1))));
      chk("mem_adrs", 32'(mem_adrs), 32'(m_adrs));
      chk("mem_wd", 32'(mem_wd), 32'(m_wd));
      chk("rd", 32'(rd), 32'(m_rd));
      chk("dq_contention", 32'(dqoe && !oe_n), 32'd0);

      if (ack != 0) begin g_cyc.push_back(c); g_id.push_back(oh2i(ack)); end
      if (rdvd != 0) begin r_cyc.push_back(c); r_vec.push_back(rdvd); r_dat.push_back(rd); end
      if (!we_n) we_run++; else if (we_run > 0) begin last_we_run = we_run; we_run = 0; end
      if (!oe_n) oe_run++; else if (oe_run > 0) begin last_oe_run = oe_run; oe_run = 0; end

      if (!rst_n) begin
        m_valid = 1'b0; m_adrs = '0; m_wd = '0; m_rd = '0; m_ptr = 0; m_we = 1'b0;
      end else begin
        if (m_valid && !m_we && c == m_T + A + 1) m_rd = m_rdexp;
        if ((!m_valid || c >= m_T + A + 2) && vd != 0) begin
          w = -1;
          if (urg && vd[0]) begin
            w = 0; m_ptr = 1;
          end else begin
            for (int k = 0; k < N; k++)
              if (w < 0 && vd[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            m_ptr = (w + 1) % N;
          end
          m_valid = 1'b1; m_T = c + 1; m_id = w; m_we = we[w];
          m_adrs = adrs[w*AW +: AW];
          if (m_we) begin
            m_wd = wd[w*DW +: DW];
            ref_mem[m_adrs] = m_wd;
          end else begin
            m_rdexp = ref_mem[m_adrs];
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((rq[0].size() != 0 || rq[1].size() != 0 || rq[2].size() != 0 || busy) && n < 400) begin
      step(); n++;
    end
    total++;
    if (n >= 400) begin bad++; $display("FAIL %s_timeout act=still_busy exp=idle", nm); end
    step(); step();
  endtask

  initial begin
    int gb, rb, n;
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i] = 8'(i) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'h3C;
    end
    sram[19'h7FFFF] = 8'hC3;
    ref_mem[19'h7FFFF] = 8'hC3;

    step(); chk_en = 1'b1; step(); step();
    rst_n = 1'b1;
    chk("rst_ce", 32'(ce_n), 32'd1);
    chk("rst_dqoe", 32'(dqoe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single write from requester 1.
    gb = g_cyc.size();
    rq[1].push_back('{1'b1, 19'h00AAA, 8'h5A});
    wait_done("p1");
    chk("p1_ngrant", 32'(g_cyc.size() - gb), 32'd1);
    if (g_cyc.size() > gb) chk("p1_id", 32'(g_id[gb]), 32'd1);
    chk("p1_we_run", 32'(last_we_run), 32'd3);
    chk("p1_sram", 32'(sram[19'h00AAA]), 32'h5A);

    // Read from requester 2 at the top address.
    gb = g_cyc.size(); rb = r_cyc.size();
    rq[2].push_back('{1'b0, 19'h7FFFF, 8'h00});
    wait_done("p2");
    if (r_cyc.size() > rb && g_cyc.size() > gb) begin
      chk("p2_vec", 32'(r_vec[rb]), 32'b100);
      chk("p2_dat", 32'(r_dat[rb]), 32'hC3);
      chk("p2_lat", 32'(r_cyc[rb] - g_cyc[gb]), 32'd5);
    end else chk("p2_rdvd_seen", 32'(r_cyc.size() - rb), 32'd1);
    chk("p2_oe_run", 32'(last_oe_run), 32'd3);

    // All three held valid: round-robin 0,1,2,0,1,2 six cycles apart.
    gb = g_cyc.size();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) rq[k].push_back('{1'b0, 19'(16 + 4*r + k), 8'h00});
    wait_done("p3");
    chk("p3_ngrant", 32'(g_cyc.size() - gb), 32'd6);
    if (g_cyc.size() >= gb + 6)
      for (int i = 0; i < 6; i++) begin
        chk("p3_id", 32'(g_id[gb + i]), 32'(i % 3));
        if (i > 0) chk("p3_gap", 32'(g_cyc[gb + i] - g_cyc[gb + i - 1]), 32'd6);
      end

    // Move pointer to 2, then urgent overrides it.
    rq[0].push_back('{1'b1, 19'h00100, 8'h11});
    rq[1].push_back('{1'b1, 19'h00101, 8'h22});
    wait_done("p4a");
    gb = g_cyc.size();
    urg = 1'b1;
    for (int k = 0; k < N; k++) rq[k].push_back('{1'b0, 19'h00100 + 19'(k), 8'h00});
    n = 0;
    while (g_cyc.size() == gb && n < 50) begin step(); n++; end
    urg = 1'b0;
    wait_done("p4b");
    chk("p4_ngrant", 32'(g_cyc.size() - gb), 32'd3);
    if (g_cyc.size() >= gb + 3) begin
      chk("p4_urgent", 32'(g_id[gb]), 32'd0);
      chk("p4_next", 32'(g_id[gb + 1]), 32'd1);
      chk("p4_last", 32'(g_id[gb + 2]), 32'd2);
    end

    // Write then read same address.
    rb = r_cyc.size();
    rq[1].push_back('{1'b1, 19'h12345, 8'h9E});
    rq[1].push_back('{1'b0, 19'h12345, 8'h00});
    wait_done("p5");
    chk("p5_nrd", 32'(r_cyc.size() - rb), 32'd1);
    if (r_cyc.size() > rb) begin
      chk("p5_dat", 32'(r_dat[rb]), 32'h9E);
      chk("p5_vec", 32'(r_vec[rb]), 32'b010);
    end

    // Reset during the ACCESS phase of a read.
    rb = r_cyc.size();
    rq[2].push_back('{1'b0, 19'h7FFFF, 8'h00});
    n = 0;
    while (!ack[2] && n < 50) begin step(); n++; end
    chk("p6_ack_seen", 32'(ack[2]), 32'd1);
    step(); step();
    chk("p6_oe_low", 32'(oe_n), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("p6_ce", 32'(ce_n), 32'd1);
    chk("p6_oe", 32'(oe_n), 32'd1);
    chk("p6_we", 32'(we_n), 32'd1);
    chk("p6_dqoe", 32'(dqoe), 32'd0);
    repeat (8) step();
    chk("p6_no_rdvd", 32'(r_cyc.size() - rb), 32'd0);
    rq[2].push_back('{1'b0, 19'h7FFFF, 8'h00});
    wait_done("p6");
    chk("p6_nrd", 32'(r_cyc.size() - rb), 32'd1);
    if (r_cyc.size() > rb) begin
      chk("p6_vec", 32'(r_vec[rb]), 32'b100);
      chk("p6_dat", 32'(r_dat[rb]), 32'hC3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
